// File: rtl/multiplier_pkg.sv
// Shared execute-stage definitions: ALU op codes for the M extension and the
// multicycle handshake states reused by the multiplier and the divider.
package multiplier_pkg;

  localparam int W = 32;

  localparam logic [5:0] ALU_MUL    = 6'd24;
  localparam logic [5:0] ALU_MULH   = 6'd25;
  localparam logic [5:0] ALU_MULHSU = 6'd26;
  localparam logic [5:0] ALU_MULHU  = 6'd27;
  localparam logic [5:0] ALU_DIV    = 6'd28;
  localparam logic [5:0] ALU_DIVU   = 6'd29;
  localparam logic [5:0] ALU_REM    = 6'd30;
  localparam logic [5:0] ALU_REMU   = 6'd31;

  // One radix-2 step per operand bit.
  localparam int MC_ITER = 32;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_CALC = 2'd1,
    MC_FIX  = 2'd2
  } mc_state_e;

  function automatic logic is_mul_op(input logic [5:0] c);
    return (c == ALU_MUL) || (c == ALU_MULH) || (c == ALU_MULHSU) || (c == ALU_MULHU);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Multicycle RV32M multiplier: radix-2 shift-add on operand magnitudes,
// then sign fix-up and high/low word select. Fixed 34-cycle latency.
module multiplier
  import multiplier_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    alucode,
  input  logic [W-1:0]  op1,
  input  logic [W-1:0]  op2,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  multiplier_result
);

  mc_state_e        state, state_nxt;
  logic [2*W-1:0]   mcand, acc, prod;
  logic [W-1:0]     mplr, a_mag, b_mag, res_sel;
  logic [4:0]       cnt;
  logic [5:0]       op;
  logic             neg, a_neg, b_neg, accept, last;

  assign accept = start && is_mul_op(alucode);
  assign last   = (cnt == 5'(MC_ITER - 1));
  assign busy   = (state != MC_IDLE);

  // Only op1 is signed for MULHSU; MUL low word is sign-agnostic, so unsigned.
  assign a_neg = ((alucode == ALU_MULH) || (alucode == ALU_MULHSU)) && op1[W-1];
  assign b_neg = (alucode == ALU_MULH) && op2[W-1];
  assign a_mag = a_neg ? -op1 : op1;
  assign b_mag = b_neg ? -op2 : op2;

  assign prod    = neg ? -acc : acc;
  assign res_sel = (op == ALU_MUL) ? prod[W-1:0] : prod[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MC_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MC_IDLE: if (accept) state_nxt = MC_CALC;
      MC_CALC: if (last)   state_nxt = MC_FIX;
      MC_FIX:              state_nxt = MC_IDLE;
      default:             state_nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand             <= '0;
      mplr              <= '0;
      acc               <= '0;
      cnt               <= '0;
      neg               <= 1'b0;
      op                <= '0;
      done              <= 1'b0;
      multiplier_result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MC_IDLE: if (accept) begin
          mcand <= {{W{1'b0}}, a_mag};
          mplr  <= b_mag;
          neg   <= a_neg ^ b_neg;
          op    <= alucode;
          acc   <= '0;
          cnt   <= '0;
        end
        MC_CALC: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 5'd1;
        end
        MC_FIX: begin
          multiplier_result <= res_sel;
          done              <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
